// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive buffer
package uart_pkg;

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    localparam int UART_RX_FIFO_DEFAULT_DEPTH = 16;
    localparam int UART_TIMEOUT_W             = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - entry storage with one write port and an asynchronous head read
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  rx_entry_t        wdata,
    input  logic [PTR_W-1:0] raddr,
    output rx_entry_t        rdata
);

    rx_entry_t mem [DEPTH];

    // Storage is deliberately not reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT receive FIFO with parity tagging, sticky status and level/timeout interrupts
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH           = UART_RX_FIFO_DEFAULT_DEPTH,
    parameter bit STORE_BAD_BYTES = 1'b1,
    localparam int CW             = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_valid_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_parity_error_i,
    input  logic                      rd_en_i,
    output logic [7:0]                rd_data_o,
    output logic                      rd_perr_o,
    input  logic                      flush_i,
    input  logic                      clr_status_i,
    input  logic [CW-1:0]             thresh_i,
    input  logic [UART_TIMEOUT_W-1:0] timeout_i,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [CW-1:0]             count_o,
    output logic                      overrun_o,
    output logic                      parity_err_o,
    output logic                      irq_level_o,
    output logic                      irq_timeout_o
);

    localparam int PTR_W = CW - 1;

    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             count_q, count_nxt;
    logic [UART_TIMEOUT_W-1:0] idle_q;
    logic                      perr_q;
    logic                      overrun_q, parity_err_q, irq_timeout_q;

    logic      bad_edge, push_req, push_ok, pop_ok, overrun_evt, idle_clr, timeout_hit;
    rx_entry_t push_entry, head_entry;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    // The receiver signals a bad byte with a level; only its rising edge is an event.
    assign bad_edge   = rx_parity_error_i & ~perr_q;
    assign push_req   = rx_valid_i | (bad_edge & STORE_BAD_BYTES);
    assign push_entry = '{perr: ~rx_valid_i, data: rx_data_i};

    assign pop_ok      = rd_en_i & ~empty_o & ~flush_i;
    assign push_ok     = push_req & ~flush_i & (~full_o | pop_ok);
    assign overrun_evt = push_req & ~flush_i & full_o & ~pop_ok;

    assign idle_clr    = push_ok | pop_ok | flush_i | empty_o;
    assign timeout_hit = (timeout_i != '0) && (idle_q == timeout_i - 16'd1);

    always_comb begin
        count_nxt = count_q;
        if (flush_i) begin
            count_nxt = '0;
        end else begin
            count_nxt = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            idle_q        <= '0;
            perr_q        <= 1'b0;
            overrun_q     <= 1'b0;
            parity_err_q  <= 1'b0;
            irq_timeout_q <= 1'b0;
        end else begin
            perr_q  <= rx_parity_error_i;
            count_q <= count_nxt;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            // A same-cycle event beats the clear so no error is ever missed.
            overrun_q    <= overrun_evt | (overrun_q & ~clr_status_i);
            parity_err_q <= bad_edge | (parity_err_q & ~clr_status_i);

            if (idle_clr) begin
                idle_q        <= '0;
                irq_timeout_q <= 1'b0;
            end else begin
                if (idle_q != '1) idle_q <= idle_q + 16'd1;
                if (timeout_hit)  irq_timeout_q <= 1'b1;
            end
        end
    end

    uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (push_entry),
        .raddr (rd_ptr_q),
        .rdata (head_entry)
    );

    assign rd_data_o     = head_entry.data;
    assign rd_perr_o     = head_entry.perr;
    assign count_o       = count_q;
    assign overrun_o     = overrun_q;
    assign parity_err_o  = parity_err_q;
    assign irq_level_o   = (thresh_i != '0) && (count_q >= thresh_i);
    assign irq_timeout_o = irq_timeout_q;

endmodule
